// File: rtl/regfile_sweep.sv
// regfile_sweep: MIPS general-purpose register file with two combinational read ports, one
// write port, optional same-cycle write-to-read bypass and a clear sequencer. The sequencer
// zeroes one entry per cycle after Reset or Clear, so the array needs no per-bit reset and
// can map to distributed RAM.
//
// Ports:
//   Clock      in   rising-edge clock
//   Reset      in   synchronous active-high reset, restarts the clear sweep
//   Clear      in   synchronous request to zero the whole array
//   ReadAddr1  in   read port 1 address
//   ReadAddr2  in   read port 2 address
//   ReadData1  out  read port 1 data (combinational)
//   ReadData2  out  read port 2 data (combinational)
//   WriteAddr  in   write address
//   WriteData  in   write data
//   RegWrite   in   write enable
//   Busy       out  registered, high while the clear sweep runs
//   WriteDrop  out  registered, one-cycle pulse per write refused while Busy
module regfile_sweep #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned BYPASS   = 1,
   parameter int unsigned ZERO_REG = 1
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Clear,
   input  logic [ADDR_W-1:0] ReadAddr1,
   input  logic [ADDR_W-1:0] ReadAddr2,
   output logic [DATA_W-1:0] ReadData1,
   output logic [DATA_W-1:0] ReadData2,
   input  logic [ADDR_W-1:0] WriteAddr,
   input  logic [DATA_W-1:0] WriteData,
   input  logic              RegWrite,
   output logic              Busy,
   output logic              WriteDrop
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   typedef enum logic {StIdle, StClear} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              drop_q, drop_d;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              wr_is_zero;
   logic              busy;

   assign busy       = (state_q == StClear);
   assign wr_is_zero = (ZERO_REG != 0) && (WriteAddr == '0);

   // Next state, sweep pointer, drop flag and the single array write port.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      drop_d    = 1'b0;
      mem_we    = 1'b0;
      mem_waddr = WriteAddr;
      mem_wdata = WriteData;

      if (Reset) begin
         state_d = StClear;
         ptr_d   = '0;
      end else begin
         // A refused write is flagged whether or not Clear restarts the sweep.
         drop_d = busy && RegWrite && !wr_is_zero;
         if (Clear) begin
            // Restart without writing: the sweep will zero everything anyway.
            state_d = StClear;
            ptr_d   = '0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  mem_we = RegWrite && !wr_is_zero;
               end
               StClear: begin
                  mem_we    = 1'b1;
                  mem_waddr = ptr_q;
                  mem_wdata = '0;
                  ptr_d     = ptr_q + 1'b1;
                  if (&ptr_q) begin
                     state_d = StIdle;
                  end
               end
               default: begin
                  state_d = StClear;
                  ptr_d   = '0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= StClear;
         ptr_q   <= '0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         drop_q  <= drop_d;
      end
   end

   // Storage has no reset; the sweep provides the zeroing.
   always_ff @(posedge Clock) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   assign Busy      = busy;
   assign WriteDrop = drop_q;

   always_comb begin
      ReadData1 = mem[ReadAddr1];
      if (busy) begin
         ReadData1 = '0;
      end else if ((ZERO_REG != 0) && (ReadAddr1 == '0)) begin
         ReadData1 = '0;
      end else if ((BYPASS != 0) && RegWrite && (ReadAddr1 == WriteAddr)) begin
         ReadData1 = WriteData;
      end
   end

   always_comb begin
      ReadData2 = mem[ReadAddr2];
      if (busy) begin
         ReadData2 = '0;
      end else if ((ZERO_REG != 0) && (ReadAddr2 == '0)) begin
         ReadData2 = '0;
      end else if ((BYPASS != 0) && RegWrite && (ReadAddr2 == WriteAddr)) begin
         ReadData2 = WriteData;
      end
   end

endmodule
